iniciador_conjunto_reg: RTL and testbench

Read/write-back sequencer that drives the three ports of `conjunto_reg32x32` (synchronous, enable-gated 2R1W register file) on behalf of a multi-cycle RV32I core. It accepts one instruction word, decodes rs1/rs2/rd, issues the reads, captures the operands one cycle later, and hands them to the execute stage over a valid/ready handshake. Write-backs from the core pass straight to the write port. Any write-back that hits a pending source register is forwarded into the operand.

---
 rtl/iniciador_conjunto_reg.sv | 144 ++++++++++++++
 tb/tb_iniciador_conjunto_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/iniciador_conjunto_reg.sv
`default_nettype none
// ============================================================================
// Module  : iniciador_conjunto_reg
// Brief   : Operand-fetch sequencer for a 2R1W register file, with
//           write-back forwarding into pending operands.
// Revision: 1.0
// ============================================================================
module iniciador_conjunto_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valida,
  input  logic [31:0] instr,
  output logic        instr_lista,
  output logic        op_valido,
  input  logic        op_listo,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic [4:0]  rd,
  input  logic        wb_valido,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_dato,
  output logic        hab_w,
  output logic [4:0]  addr_w,
  output logic [31:0] data_w,
  output logic        hab_r1,
  output logic [4:0]  addr_r1,
  input  logic [31:0] data_r1,
  output logic        hab_r2,
  output logic [4:0]  addr_r2,
  input  logic [31:0] data_r2
);

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    LECTURA  = 2'd1,
    CAPTURA  = 2'd2,
    ENTREGA  = 2'd3
  } estado_t;

  estado_t     state_q;
  logic        instr_lista_q, op_valido_q, hab_r1_q, hab_r2_q;
  logic        usa1_q, usa2_q, fwd1_v_q, fwd2_v_q;
  logic [4:0]  addr_r1_q, addr_r2_q, rd_q;
  logic [31:0] rs1_val_q, rs2_val_q, fwd1_dat_q, fwd2_dat_q;

  logic        w_usa1, w_usa2, w_sin_rd, w_hit1, w_hit2;
  logic [6:0]  w_opc;

  always_comb begin
    w_opc    = instr[6:0];
    w_usa1   = 1'b0;
    w_usa2   = 1'b0;
    w_sin_rd = 1'b0;
    case (w_opc)
      7'b0110011:             begin w_usa1 = 1'b1; w_usa2 = 1'b1; end
      7'b0100011, 7'b1100011: begin w_usa1 = 1'b1; w_usa2 = 1'b1; w_sin_rd = 1'b1; end
      7'b0010011, 7'b0000011, 7'b1100111: w_usa1 = 1'b1;
      default: ;
    endcase
  end

  // Unused sources are latched as x0, so a nonzero address match implies usage.
  assign w_hit1 = wb_valido && (wb_rd != 5'd0) && usa1_q && (wb_rd == addr_r1_q);
  assign w_hit2 = wb_valido && (wb_rd != 5'd0) && usa2_q && (wb_rd == addr_r2_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= INACTIVO;
      instr_lista_q <= 1'b1;
      op_valido_q   <= 1'b0;
      hab_r1_q      <= 1'b0;
      hab_r2_q      <= 1'b0;
      usa1_q        <= 1'b0;
      usa2_q        <= 1'b0;
      fwd1_v_q      <= 1'b0;
      fwd2_v_q      <= 1'b0;
      addr_r1_q     <= 5'd0;
      addr_r2_q     <= 5'd0;
      rd_q          <= 5'd0;
      rs1_val_q     <= 32'd0;
      rs2_val_q     <= 32'd0;
      fwd1_dat_q    <= 32'd0;
      fwd2_dat_q    <= 32'd0;
    end else begin
      case (state_q)
        INACTIVO: begin
          if (instr_valida) begin
            state_q       <= LECTURA;
            instr_lista_q <= 1'b0;
            usa1_q        <= w_usa1;
            usa2_q        <= w_usa2;
            hab_r1_q      <= w_usa1;
            hab_r2_q      <= w_usa2;
            addr_r1_q     <= w_usa1 ? instr[19:15] : 5'd0;
            addr_r2_q     <= w_usa2 ? instr[24:20] : 5'd0;
            rd_q          <= w_sin_rd ? 5'd0 : instr[11:7];
            fwd1_v_q      <= 1'b0;
            fwd2_v_q      <= 1'b0;
          end
        end
        LECTURA: begin
          state_q  <= CAPTURA;
          hab_r1_q <= 1'b0;
          hab_r2_q <= 1'b0;
          if (w_hit1) begin fwd1_v_q <= 1'b1; fwd1_dat_q <= wb_dato; end
          if (w_hit2) begin fwd2_v_q <= 1'b1; fwd2_dat_q <= wb_dato; end
        end
        CAPTURA: begin
          // A write-back in this very cycle is newer than any recorded one.
          state_q     <= ENTREGA;
          op_valido_q <= 1'b1;
          rs1_val_q   <= !usa1_q ? 32'd0 : w_hit1 ? wb_dato : fwd1_v_q ? fwd1_dat_q : data_r1;
          rs2_val_q   <= !usa2_q ? 32'd0 : w_hit2 ? wb_dato : fwd2_v_q ? fwd2_dat_q : data_r2;
        end
        ENTREGA: begin
          if (w_hit1) rs1_val_q <= wb_dato;
          if (w_hit2) rs2_val_q <= wb_dato;
          if (op_listo) begin
            state_q       <= INACTIVO;
            op_valido_q   <= 1'b0;
            instr_lista_q <= 1'b1;
          end
        end
        default: state_q <= INACTIVO;
      endcase
    end
  end

  assign instr_lista = instr_lista_q;
  assign op_valido   = op_valido_q;
  assign hab_r1      = hab_r1_q;
  assign hab_r2      = hab_r2_q;
  assign addr_r1     = addr_r1_q;
  assign addr_r2     = addr_r2_q;
  assign rs1_val     = rs1_val_q;
  assign rs2_val     = rs2_val_q;
  assign rd          = rd_q;

  assign hab_w  = wb_valido & (wb_rd != 5'd0) & ~rst;
  assign addr_w = wb_rd;
  assign data_w = wb_dato;

endmodule
`default_nettype wire

// File: tb/tb_iniciador_conjunto_reg.sv
`default_nettype none
// Directed bench for iniciador_conjunto_reg with a behavioural 2R1W register file.
module tb_iniciador_conjunto_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valida;
  logic [31:0] instr;
  logic        instr_lista, op_valido, op_listo;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd;
  logic        wb_valido;
  logic [4:0]  wb_rd;
  logic [31:0] wb_dato;
  logic        hab_w, hab_r1, hab_r2;
  logic [4:0]  addr_w, addr_r1, addr_r2;
  logic [31:0] data_w, data_r1, data_r2;

  logic [31:0] regs [32];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iniciador_conjunto_reg dut (
    .clk(clk), .rst(rst),
    .instr_valida(instr_valida), .instr(instr), .instr_lista(instr_lista),
    .op_valido(op_valido), .op_listo(op_listo),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd),
    .wb_valido(wb_valido), .wb_rd(wb_rd), .wb_dato(wb_dato),
    .hab_w(hab_w), .addr_w(addr_w), .data_w(data_w),
    .hab_r1(hab_r1), .addr_r1(addr_r1), .data_r1(data_r1),
    .hab_r2(hab_r2), .addr_r2(addr_r2), .data_r2(data_r2)
  );

  // Register file: enable-gated reads, x0 hardwired, read-during-write gives old data.
  always @(posedge clk) begin
    if (hab_r1) data_r1 <= (addr_r1 == 5'd0) ? 32'd0 : regs[addr_r1];
    if (hab_r2) data_r2 <= (addr_r2 == 5'd0) ? 32'd0 : regs[addr_r2];
    if (hab_w && addr_w != 5'd0) regs[addr_w] <= data_w;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    data_r1 = 32'd0; data_r2 = 32'd0;
    rst = 1'b1; instr_valida = 1'b0; instr = 32'd0; op_listo = 1'b0;
    wb_valido = 1'b0; wb_rd = 5'd0; wb_dato = 32'd0;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_instr_lista", {31'd0, instr_lista}, 32'd1);
    chk("reset_op_valido",   {31'd0, op_valido},   32'd0);
    chk("reset_hab_r",       {30'd0, hab_r1, hab_r2}, 32'd0);
    chk("reset_addr_r",      {22'd0, addr_r1, addr_r2}, 32'd0);
    chk("reset_operands",    rs1_val | rs2_val, 32'd0);
    chk("reset_rd",          {27'd0, rd}, 32'd0);

    // Preload x1 and x2 through the write-back path
    wb_valido = 1'b1; wb_rd = 5'd1; wb_dato = 32'h5041544F;
    #1;
    chk("wb_hab_w",   {31'd0, hab_w}, 32'd1);
    chk("wb_addr_w",  {27'd0, addr_w}, 32'd1);
    chk("wb_data_w",  data_w, 32'h5041544F);
    step();
    wb_rd = 5'd2; wb_dato = 32'hDEADBEEF;
    step();
    wb_valido = 1'b0;

    // Reset while in LECTURA
    instr_valida = 1'b1; instr = 32'h002081B3;
    step();
    instr_valida = 1'b0;
    chk("lect_hab_r", {30'd0, hab_r1, hab_r2}, 32'd3);
    chk("lect_instr_lista", {31'd0, instr_lista}, 32'd0);
    chk("lect_addr", {22'd0, addr_r1, addr_r2}, {22'd0, 5'd1, 5'd2});
    rst = 1'b1;
    #1;
    chk("rstmid_hab_r", {30'd0, hab_r1, hab_r2}, 32'd0);
    chk("rstmid_op_valido", {31'd0, op_valido}, 32'd0);
    chk("rstmid_hab_w", {31'd0, hab_w}, 32'd0);
    rst = 1'b0;
    step();
    chk("rstmid_instr_lista", {31'd0, instr_lista}, 32'd1);

    // ADD x3,x1,x2
    instr_valida = 1'b1; instr = 32'h002081B3;
    step();
    instr_valida = 1'b0;
    chk("add_lat_e0", {31'd0, op_valido}, 32'd0);
    step();
    chk("add_lat_e1", {31'd0, op_valido}, 32'd0);
    step();
    chk("add_op_valido", {31'd0, op_valido}, 32'd1);
    chk("add_rs1", rs1_val, 32'h5041544F);
    chk("add_rs2", rs2_val, 32'hDEADBEEF);
    chk("add_rd",  {27'd0, rd}, 32'd3);
    chk("add_instr_lista", {31'd0, instr_lista}, 32'd0);
    op_listo = 1'b1;
    step();
    op_listo = 1'b0;
    chk("add_done_op_valido", {31'd0, op_valido}, 32'd0);
    chk("add_done_instr_lista", {31'd0, instr_lista}, 32'd1);

    // ADDI x5,x0,1: rs2 unused
    instr_valida = 1'b1; instr = 32'h00100293;
    step();
    instr_valida = 1'b0;
    chk("addi_hab_r_e0", {30'd0, hab_r1, hab_r2}, 32'd2);
    step();
    chk("addi_hab_r_e1", {30'd0, hab_r1, hab_r2}, 32'd0);
    step();
    chk("addi_op_valido", {31'd0, op_valido}, 32'd1);
    chk("addi_rs1", rs1_val, 32'd0);
    chk("addi_rs2", rs2_val, 32'd0);
    chk("addi_rd",  {27'd0, rd}, 32'd5);
    op_listo = 1'b1;
    step();
    op_listo = 1'b0;

    // Forwarding from LECTURA and CAPTURA
    instr_valida = 1'b1; instr = 32'h002081B3;
    step();
    instr_valida = 1'b0;
    wb_valido = 1'b1; wb_rd = 5'd1; wb_dato = 32'h12345678;
    step();
    wb_rd = 5'd2; wb_dato = 32'hCAFEBABE;
    step();
    wb_valido = 1'b0;
    chk("fwd_rs1", rs1_val, 32'h12345678);
    chk("fwd_rs2", rs2_val, 32'hCAFEBABE);

    // Stall in ENTREGA for 5 cycles, write-back to x1 in cycle 3
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin wb_valido = 1'b1; wb_rd = 5'd1; wb_dato = 32'h0BADF00D; end
      step();
      wb_valido = 1'b0;
      chk("stall_op_valido", {31'd0, op_valido}, 32'd1);
      chk("stall_instr_lista", {31'd0, instr_lista}, 32'd0);
      chk("stall_rs1", rs1_val, (i >= 2) ? 32'h0BADF00D : 32'h12345678);
      chk("stall_rs2", rs2_val, 32'hCAFEBABE);
    end
    op_listo = 1'b1;
    step();
    op_listo = 1'b0;

    // Write-back to x0 during an x0 read: ignored and never forwarded
    instr_valida = 1'b1; instr = 32'h00100293;
    step();
    instr_valida = 1'b0;
    wb_valido = 1'b1; wb_rd = 5'd0; wb_dato = 32'h11111111;
    #1;
    chk("x0_hab_w", {31'd0, hab_w}, 32'd0);
    step();
    wb_valido = 1'b0;
    step();
    chk("x0_op_valido", {31'd0, op_valido}, 32'd1);
    chk("x0_rs1", rs1_val, 32'd0);
    chk("x0_rd",  {27'd0, rd}, 32'd5);
    op_listo = 1'b1;
    step();
    op_listo = 1'b0;
    chk("x0_regfile", regs[0], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
